// File: rtl/truth_table_sweeper_if.sv
// Bundle between the truth-table sweeper and its controller / unit under test.
// No storage here; the sweeper drives the UUT inputs and the status/result fields.
// No backpressure: start is a request sampled only while the sweeper is idle.
interface truth_table_sweeper_if;
  logic       start;
  logic [7:0] expected;
  logic       uut_y;
  logic       uut_a;
  logic       uut_b;
  logic       uut_c;
  logic       busy;
  logic       done;
  logic [7:0] table_out;
  logic       match;
`ifdef SWEEP_MISMATCH_EN
  logic [3:0] mismatch_cnt;
  logic [2:0] first_bad;
  logic       first_bad_valid;

  modport master (
    output start, expected, uut_y,
    input  uut_a, uut_b, uut_c, busy, done, table_out, match,
    input  mismatch_cnt, first_bad, first_bad_valid
  );

  modport slave (
    input  start, expected, uut_y,
    output uut_a, uut_b, uut_c, busy, done, table_out, match,
    output mismatch_cnt, first_bad, first_bad_valid
  );
`else
  modport master (
    output start, expected, uut_y,
    input  uut_a, uut_b, uut_c, busy, done, table_out, match
  );

  modport slave (
    input  start, expected, uut_y,
    output uut_a, uut_b, uut_c, busy, done, table_out, match
  );
`endif
endinterface

// File: rtl/truth_table_sweeper.sv
// Applies vectors 000..111 to a 3-in/1-out UUT, captures Y into an 8-bit table, compares to expected.
// Latency: accepted start at edge 0 -> 8*SETTLE_CYCLES DRIVE cycles, done sampled high at edge 8*SETTLE_CYCLES+1.
// No backpressure: start is dropped (not queued) while busy or in DONE. Optional SWEEP_MISMATCH_EN adds mismatch stats.
module truth_table_sweeper #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  truth_table_sweeper_if.slave sw
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       tbl_q, tbl_d;
  logic [7:0]       exp_q, exp_d;
  logic             match_q, match_d;
  logic [7:0]       cap_tbl;
  logic             accept;
  logic             settle_hit;
  logic             finish;

  assign accept     = (state_q == S_IDLE) && sw.start;
  assign settle_hit = (state_q == S_DRIVE) && (cnt_q == CNT_W'(SETTLE_CYCLES - 1));
  assign finish     = settle_hit && (vec_q == 3'd7);

  // Table as it will look once the current vector's Y is written in.
  always_comb begin
    cap_tbl        = tbl_q;
    cap_tbl[vec_q] = sw.uut_y;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and datapath next values; every field defaults to hold.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    tbl_d   = tbl_q;
    exp_d   = exp_q;
    match_d = match_q;
    case (state_q)
      S_IDLE: begin
        if (sw.start) begin
          exp_d   = sw.expected;
          vec_d   = 3'd0;
          cnt_d   = '0;
          tbl_d   = 8'h00;
          match_d = 1'b0;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (settle_hit) begin
          tbl_d = cap_tbl;
          cnt_d = '0;
          if (vec_q == 3'd7) begin
            match_d = (cap_tbl == exp_q);
            state_d = S_DONE;
          end else begin
            vec_d = vec_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath registers; reset also discards any partial table.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vec_q   <= 3'd0;
      cnt_q   <= '0;
      tbl_q   <= 8'h00;
      exp_q   <= 8'h00;
      match_q <= 1'b0;
    end else begin
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      tbl_q   <= tbl_d;
      exp_q   <= exp_d;
      match_q <= match_d;
    end
  end

  // UUT inputs come straight from registers and read 000 outside DRIVE.
  assign sw.uut_a     = (state_q == S_DRIVE) & vec_q[2];
  assign sw.uut_b     = (state_q == S_DRIVE) & vec_q[1];
  assign sw.uut_c     = (state_q == S_DRIVE) & vec_q[0];
  assign sw.busy      = (state_q == S_DRIVE);
  assign sw.done      = (state_q == S_DONE);
  assign sw.table_out = tbl_q;
  assign sw.match     = match_q;

`ifdef SWEEP_MISMATCH_EN
  logic [7:0] diff;
  logic [3:0] pop;
  logic [2:0] low_bad;
  logic [3:0] mm_cnt_q;
  logic [2:0] fb_q;
  logic       fbv_q;

  // Popcount and lowest failing index of the final captured table.
  always_comb begin
    diff    = cap_tbl ^ exp_q;
    pop     = 4'd0;
    low_bad = 3'd0;
    for (int i = 0; i < 8; i++) begin
      pop = pop + 4'(diff[i]);
    end
    for (int i = 7; i >= 0; i--) begin
      if (diff[i]) low_bad = 3'(i);
    end
  end

  // Mismatch statistics: cleared on start, loaded as the sweep finishes.
  always_ff @(posedge clk) begin
    if (!rst_n || accept) begin
      mm_cnt_q <= 4'd0;
      fb_q     <= 3'd0;
      fbv_q    <= 1'b0;
    end else if (finish) begin
      mm_cnt_q <= pop;
      fb_q     <= low_bad;
      fbv_q    <= (diff != 8'h00);
    end
  end

  assign sw.mismatch_cnt    = mm_cnt_q;
  assign sw.first_bad       = fb_q;
  assign sw.first_bad_valid = fbv_q;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: majority UUT at SETTLE_CYCLES=2, XOR3 UUT at SETTLE_CYCLES=1.
// Edge numbering: the edge that accepts start is edge 0; "done edge" is the first edge that samples done=1.
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
module tb_truth_table_sweeper;

  logic clk;
  logic rst_n;
  int   n_err;
  int   n_checks;
  int   cur;

  truth_table_sweeper_if if_a ();
  truth_table_sweeper_if if_b ();

  truth_table_sweeper #(.SETTLE_CYCLES(2), .CNT_W(4)) dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .sw   (if_a.slave)
  );

  truth_table_sweeper #(.SETTLE_CYCLES(1), .CNT_W(4)) dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .sw   (if_b.slave)
  );

  // UUT models: 3-input majority and 3-input XOR.
  assign if_a.uut_y = (if_a.uut_a & if_a.uut_b) | (if_a.uut_a & if_a.uut_c) | (if_a.uut_b & if_a.uut_c);
  assign if_b.uut_y = if_b.uut_a ^ if_b.uut_b ^ if_b.uut_c;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       cur_busy, cur_done, cur_match;
  logic [2:0] cur_abc;
  logic [7:0] cur_tbl;
  assign cur_busy  = (cur == 0) ? if_a.busy : if_b.busy;
  assign cur_done  = (cur == 0) ? if_a.done : if_b.done;
  assign cur_match = (cur == 0) ? if_a.match : if_b.match;
  assign cur_abc   = (cur == 0) ? {if_a.uut_a, if_a.uut_b, if_a.uut_c} : {if_b.uut_a, if_b.uut_b, if_b.uut_c};
  assign cur_tbl   = (cur == 0) ? if_a.table_out : if_b.table_out;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (cur == 0) if_a.start = v;
    else          if_b.start = v;
  endtask

  task automatic set_exp(input logic [7:0] v);
    if (cur == 0) if_a.expected = v;
    else          if_b.expected = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One sweep on instance cur. extra: re-pulse start at cycles 5 and 10.
  // rst_at >= 0: hold rst_n low for the edge with that number. Expected is
  // disturbed at cycle 3 to confirm it was latched.
  task automatic run_sweep(input int settle, input logic [7:0] exp_v, input bit extra, input int rst_at,
                           output int done_edge, output int done_cnt, output int busy_cnt, output int seq_err);
    done_edge = -1;
    done_cnt  = 0;
    busy_cnt  = 0;
    seq_err   = 0;
    set_exp(exp_v);
    set_start(1'b1);
    step();                                   // edge 0 accepts start
    for (int k = 1; k <= 40; k++) begin
      set_start(extra && (k == 5 || k == 10));
      rst_n = (k == rst_at) ? 1'b0 : 1'b1;
      if (k == 3) set_exp(~exp_v);
      if (cur_busy) busy_cnt++;
      if (cur_done) begin
        done_cnt++;
        if (done_edge < 0) done_edge = k;
      end
      if (rst_at < 0 && (k - 1) < 8 * settle && cur_abc !== 3'((k - 1) / settle)) seq_err++;
      step();
    end
    set_start(1'b0);
    rst_n = 1'b1;
  endtask

  int de, dc, bc, se;
  int d1, d2, cnt2;

  initial begin
    n_err         = 0;
    n_checks      = 0;
    cur           = 0;
    rst_n         = 1'b0;
    if_a.start    = 1'b0;
    if_a.expected = 8'h00;
    if_b.start    = 1'b0;
    if_b.expected = 8'h00;
    repeat (3) step();
    rst_n = 1'b1;

    // Idle for 20 cycles with no start.
    bc = 0;
    dc = 0;
    for (int k = 0; k < 20; k++) begin
      if (cur_busy) bc++;
      if (cur_done) dc++;
      step();
    end
    check("idle_busy_cycles", bc, 0);
    check("idle_done_cycles", dc, 0);
    check("idle_abc", cur_abc, 3'b000);
    check("idle_table", cur_tbl, 8'h00);
    check("idle_match", cur_match, 1'b0);

    // Majority, correct expected.
    run_sweep(2, 8'hE8, 1'b0, -1, de, dc, bc, se);
    check("maj_done_edge", de, 17);
    check("maj_done_cnt", dc, 1);
    check("maj_busy_cycles", bc, 16);
    check("maj_vector_seq_errs", se, 0);
    check("maj_table", cur_tbl, 8'hE8);
    check("maj_match", cur_match, 1'b1);
    check("maj_abc_after", cur_abc, 3'b000);
`ifdef SWEEP_MISMATCH_EN
    check("maj_mm_cnt", if_a.mismatch_cnt, 4'd0);
    check("maj_fb_valid", if_a.first_bad_valid, 1'b0);
`endif

    // Majority, expected off in bit 0.
    run_sweep(2, 8'hE9, 1'b0, -1, de, dc, bc, se);
    check("bad_done_edge", de, 17);
    check("bad_table", cur_tbl, 8'hE8);
    check("bad_match", cur_match, 1'b0);
`ifdef SWEEP_MISMATCH_EN
    check("bad_mm_cnt", if_a.mismatch_cnt, 4'd1);
    check("bad_first_bad", if_a.first_bad, 3'd0);
    check("bad_fb_valid", if_a.first_bad_valid, 1'b1);
`endif

    // Start re-pulsed at cycles 5 and 10 is ignored.
    run_sweep(2, 8'hE8, 1'b1, -1, de, dc, bc, se);
    check("ign_done_edge", de, 17);
    check("ign_done_cnt", dc, 1);
    check("ign_busy_cycles", bc, 16);
    check("ign_match", cur_match, 1'b1);

    // Reset at edge 9 aborts without done and clears the table.
    run_sweep(2, 8'hE8, 1'b0, 9, de, dc, bc, se);
    check("rst_done_cnt", dc, 0);
    check("rst_busy_cycles", bc, 9);
    check("rst_table", cur_tbl, 8'h00);
    check("rst_match", cur_match, 1'b0);
    run_sweep(2, 8'hE8, 1'b0, -1, de, dc, bc, se);
    check("post_rst_done_edge", de, 17);
    check("post_rst_table", cur_tbl, 8'hE8);
    check("post_rst_match", cur_match, 1'b1);

    // Start held high: second sweep accepted at edge 18, done at edge 35.
    d1   = -1;
    d2   = -1;
    cnt2 = 0;
    set_exp(8'hE8);
    set_start(1'b1);
    step();
    for (int k = 1; k <= 60; k++) begin
      if (k >= 36) set_start(1'b0);
      if (cur_done) begin
        cnt2++;
        if (d1 < 0) d1 = k;
        else if (d2 < 0) d2 = k;
      end
      step();
    end
    check("hold_first_done", d1, 17);
    check("hold_second_done", d2, 35);
    check("hold_done_cnt", cnt2, 2);

    // XOR3 at SETTLE_CYCLES=1.
    cur = 1;
    run_sweep(1, 8'h96, 1'b0, -1, de, dc, bc, se);
    check("xor_done_edge", de, 9);
    check("xor_busy_cycles", bc, 8);
    check("xor_vector_seq_errs", se, 0);
    check("xor_table", cur_tbl, 8'h96);
    check("xor_match", cur_match, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequencer for a 3-input, 1-output combinational unit under test (UUT).
- On a start pulse it applies all 8 input vectors {A,B,C} = 000..111 in order and holds each for a programmable settle time.
- It samples the UUT output Y for each vector and assembles an 8-bit captured truth table, then compares it against an expected table.
- Sits beside a combinational exercise module in on-board / self-check builds and replaces manual stimulus.

Parameters:
- SETTLE_CYCLES, 2, cycles each vector is held before Y is sampled; legal range 1..15.
- CNT_W, 4, width of the settle counter; must hold SETTLE_CYCLES-1.

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to begin a sweep; honoured only in IDLE.
- expected  in  8  expected truth table; bit i = Y for vector i, where i = {A,B,C} and A is the MSB. Latched on an accepted start.
- uut_y  in  1  UUT output.
- uut_a  out  1  UUT input A (vector bit 2).
- uut_b  out  1  UUT input B (vector bit 1).
- uut_c  out  1  UUT input C (vector bit 0).
- busy  out  1  high from the cycle after an accepted start through the last DRIVE cycle.
- done  out  1  one-cycle pulse when the sweep completes.
- table_out  out  8  captured truth table; held until the next accepted start.
- match  out  1  (table_out == latched expected); valid from done, held until the next accepted start.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset (rst_n=0 at a clk edge) puts the block in IDLE and clears: vector=0, settle counter=0, uut_a/b/c=0, busy=0, done=0, table_out=0, match=0, expected latch=0.
- Reset mid-sweep aborts immediately. No done pulse is produced and the partial table is discarded (cleared).
- IDLE:
  - uut_a/b/c are driven to 000.
  - start=1 latches expected, sets vector=0 and counter=0, clears table_out and match, and moves to DRIVE.
- DRIVE:
  - {uut_a,uut_b,uut_c} = vector, driven from registers (no combinational path from start).
  - counter increments every cycle.
  - On the cycle where counter == SETTLE_CYCLES-1, table_out[vector] <= uut_y and counter is cleared.
  - If vector == 7 on that cycle, go to DONE; otherwise vector increments.
- DONE:
  - done=1 for exactly one cycle; match is updated from the fully captured table in the same cycle.
  - Then return to IDLE. uut_a/b/c return to 000 in DONE.
- Latency: an accepted start at edge 0 gives DRIVE for 8*SETTLE_CYCLES cycles and done high at edge 8*SETTLE_CYCLES+1 (17 for the default).
- start while busy or in DONE is ignored; it is not queued.
- start asserted continuously restarts a new sweep on the first IDLE cycle after DONE.
- The vector does not wrap past 7. Sequencing stops at 7 regardless of the counter.
- A change in expected after it is latched has no effect on the current sweep.

Optional Feature:
- Macro: SWEEP_MISMATCH_EN.
- Defined: adds the following outputs. They are cleared on reset and on an accepted start, and become valid at done:
  - mismatch_cnt (4 bits): popcount of table_out XOR expected.
  - first_bad (3 bits): lowest failing vector index.
  - first_bad_valid (1 bit): high if any mismatch exists.
- Undefined: these ports and their logic are absent; all other behaviour is unchanged.

Test Plan:
- Reset, then rst_n=1 and no start for 20 cycles -> busy=0, done=0, uut_a/b/c=000, table_out=0x00.
- UUT = 3-input majority, expected=0xE8, SETTLE_CYCLES=2, start pulse -> vectors 000..111 each held 2 cycles; done at cycle 17; table_out=0xE8, match=1.
- Same UUT, expected=0xE9 -> table_out=0xE8, match=0. With SWEEP_MISMATCH_EN: mismatch_cnt=1, first_bad=0, first_bad_valid=1.
- start pulsed again at cycles 5 and 10 of a sweep -> ignored: single done at cycle 17, no second sweep.
- rst_n=0 at cycle 9 of a sweep -> next cycle IDLE, table_out=0x00, busy=0, and no done pulse. A fresh start then completes normally.
- SETTLE_CYCLES=1, UUT Y=A^B^C, expected=0x96 -> done at cycle 9, table_out=0x96, match=1.
